// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the program-counter stage.
// Holds the sequencing state encoding, default vectors and PC step size.
package pc_gen_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_STEP  = 4;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h8000_0100;

    // Sequencing state of the PC stage.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_gen_next_adder.sv
// pc_gen_next_adder: combinational next-PC computation.
// Selects operands (imm or 4) + (rs1 or pc), adds modulo 2^XLEN, clears
// bit 0 for register-relative jumps and flags a misaligned target (bit 1).
module pc_gen_next_adder
    import pc_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            pc_a_src,
    input  logic            pc_b_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] nxt,
    output logic            misaligned
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] sum;

    // Operand muxing, wrap-around add and target alignment flag.
    always_comb begin
        op_a = pc_a_src ? imm : XLEN'(PC_STEP);
        op_b = pc_b_src ? rs1 : pc;
        sum  = op_a + op_b;
        nxt  = sum;
        if (pc_b_src) begin
            nxt[0] = 1'b0;
        end
        misaligned = nxt[1];
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter stage of the single-cycle CPU.
// Owns the PC register, BOOT/RUN/HALT sequencing, the fetch request and the
// retired-instruction counter.
// Build option: define PC_MISALIGN_TRAP_EN to redirect misaligned targets to
// TRAP_VEC with a one-cycle misalign pulse; otherwise the low two target bits
// are simply cleared.
// Fetch handshake: a request is outstanding while fetch_valid is high and is
// accepted in any cycle where fetch_ready is also high; pc stays stable while
// fetch_valid && !fetch_ready, and a commit in such a cycle is ignored.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCAsrc,
    input  logic            PCBsrc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            commit,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            halted,
    output logic            misalign,
    output logic [63:0]     instret
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [63:0]     instret_q, instret_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            halted_q, halted_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] nxt;
    logic            nxt_misaligned;
    logic [XLEN-1:0] target;
    logic            take_trap;
    logic            accept;

    pc_gen_next_adder #(
        .XLEN (XLEN)
    ) u_next_adder (
        .pc_a_src   (PCAsrc),
        .pc_b_src   (PCBsrc),
        .imm        (imm),
        .rs1        (rs1),
        .pc         (pc_q),
        .nxt        (nxt),
        .misaligned (nxt_misaligned)
    );

`ifdef PC_MISALIGN_TRAP_EN
    // Misaligned targets divert to the trap vector.
    always_comb begin
        take_trap = nxt_misaligned;
        target    = nxt_misaligned ? TRAP_VEC : nxt;
    end
`else
    // Without trapping, targets are forced word-aligned.
    always_comb begin
        take_trap = 1'b0;
        target    = {nxt[XLEN-1:2], 2'b00};
    end

    logic unused_trap;
    assign unused_trap = ^{TRAP_VEC, nxt_misaligned, nxt[1:0]};
`endif

    // Next-state, next-PC and counter logic; commits count only in RUN
    // while the current fetch request is not stalled.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        misalign_d = 1'b0;
        accept     = (state_q == ST_RUN) && commit && fetch_ready;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (accept && halt_req) state_d = ST_HALT;
            ST_HALT: if (resume) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (accept) begin
            pc_d       = target;
            instret_d  = instret_q + 64'd1;
            misalign_d = take_trap;
        end

        fetch_valid_d = (state_d == ST_RUN);
        halted_d      = (state_d == ST_HALT);
    end

    // State, PC, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VEC;
            instret_q     <= 64'd0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instret_q     <= instret_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(PC_STEP);
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign instret     = instret_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign    = misalign_q;
`else
    assign misalign    = 1'b0;

    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        PCAsrc;
    logic        PCBsrc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        commit;
    logic        halt_req;
    logic        resume;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misalign;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    int viol_cnt = 0;

    pc_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCAsrc      (PCAsrc),
        .PCBsrc      (PCBsrc),
        .imm         (imm),
        .rs1         (rs1),
        .commit      (commit),
        .halt_req    (halt_req),
        .resume      (resume),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .misalign    (misalign),
        .instret     (instret)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: commit while the fetch request is stalled.
    always @(negedge clk) begin
        if (rst_n && fetch_valid && !fetch_ready && commit) viol_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; PCAsrc = 1'b0; PCBsrc = 1'b0; imm = '0; rs1 = '0;
        commit = 1'b0; halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_pc", 64'(pc), 64'h8000_0000);
        check("rst_fv", 64'(fetch_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_instret", instret, 64'd0);

        // Release: BOOT for one cycle, then RUN
        rst_n = 1'b1;
        check("boot_pc", 64'(pc), 64'h8000_0000);
        check("boot_fv", 64'(fetch_valid), 64'd0);
        step();
        check("run_fv", 64'(fetch_valid), 64'd1);
        check("run_pc", 64'(pc), 64'h8000_0000);
        check("run_instret", instret, 64'd0);

        // Sequential commits
        commit = 1'b1;
        step(); check("seq_pc1", 64'(pc), 64'h8000_0004);
        step(); check("seq_pc2", 64'(pc), 64'h8000_0008);
        step(); check("seq_pc3", 64'(pc), 64'h8000_000C);
        commit = 1'b0;
        check("seq_instret", instret, 64'd3);
        step(); check("seq_hold", 64'(pc), 64'h8000_000C);
        commit = 1'b1;
        step(); check("seq_pc4", 64'(pc), 64'h8000_0010);

        // JALR with bit 0 cleared
        PCAsrc = 1'b1; PCBsrc = 1'b1; rs1 = 32'h8000_2001; imm = 32'd4;
        check("jalr_plus4", 64'(pc_plus4), 64'h8000_0014);
        step();
        commit = 1'b0;
        check("jalr_pc", 64'(pc), 64'h8000_2004);
        check("jalr_instret", instret, 64'd5);

        // Fetch stall: commits during the stall must be ignored
        PCAsrc = 1'b0; PCBsrc = 1'b0; fetch_ready = 1'b0; commit = 1'b1;
        step(); check("stall_pc1", 64'(pc), 64'h8000_2004);
        step(); check("stall_pc2", 64'(pc), 64'h8000_2004);
        step(); check("stall_pc3", 64'(pc), 64'h8000_2004);
        check("stall_instret", instret, 64'd5);
        check("stall_fv", 64'(fetch_valid), 64'd1);
        fetch_ready = 1'b1;
        step();
        commit = 1'b0;
        check("stall_release_pc", 64'(pc), 64'h8000_2008);
        check("stall_release_instret", instret, 64'd6);
        check("stall_viol_cnt", 64'(viol_cnt), 64'd3);

        // Move to 8000_0020 via JALR
        PCAsrc = 1'b1; PCBsrc = 1'b1; rs1 = 32'h8000_0020; imm = 32'd0; commit = 1'b1;
        step();
        commit = 1'b0;
        check("jmp20_pc", 64'(pc), 64'h8000_0020);

        // halt_req without commit is ignored
        PCAsrc = 1'b0; PCBsrc = 1'b0; halt_req = 1'b1;
        step();
        check("halt_nocommit", 64'(halted), 64'd0);

        // Halt on commit
        commit = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_pc", 64'(pc), 64'h8000_0024);
        check("halt_fv", 64'(fetch_valid), 64'd0);
        check("halt_instret", instret, 64'd8);
        step(); step();
        check("halt_hold_pc", 64'(pc), 64'h8000_0024);
        check("halt_hold_instret", instret, 64'd8);
        commit = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", 64'(halted), 64'd0);
        check("resume_fv", 64'(fetch_valid), 64'd1);
        check("resume_pc", 64'(pc), 64'h8000_0024);

        // Misaligned target from pc=8000_0000, imm=2
        PCAsrc = 1'b1; PCBsrc = 1'b1; rs1 = 32'h8000_0000; imm = 32'd0; commit = 1'b1;
        step();
        check("mis_setup_pc", 64'(pc), 64'h8000_0000);
        PCBsrc = 1'b0; imm = 32'd2;
        step();
        commit = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", 64'(pc), 64'h8000_0100);
        check("mis_pulse", 64'(misalign), 64'd1);
        check("mis_fv", 64'(fetch_valid), 64'd1);
`else
        check("mis_pc", 64'(pc), 64'h8000_0000);
        check("mis_pulse", 64'(misalign), 64'd0);
`endif
        check("mis_instret", instret, 64'd10);
        step();
        check("mis_pulse_end", 64'(misalign), 64'd0);

        // PC wrap-around at 2^32
        PCAsrc = 1'b1; PCBsrc = 1'b1; rs1 = 32'hFFFF_FFFC; imm = 32'd0; commit = 1'b1;
        step();
        commit = 1'b0;
        check("wrap_pc", 64'(pc), 64'hFFFF_FFFC);
        check("wrap_plus4", 64'(pc_plus4), 64'h0000_0000);
        PCAsrc = 1'b0; PCBsrc = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        check("wrap_next_pc", 64'(pc), 64'h0000_0000);
        check("wrap_instret", instret, 64'd12);

        // Reset mid-operation
        rst_n = 1'b0;
        step();
        check("rst2_pc", 64'(pc), 64'h8000_0000);
        check("rst2_instret", instret, 64'd0);
        check("rst2_fv", 64'(fetch_valid), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst2_run_fv", 64'(fetch_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
